i2s_rx_deserializer: RTL and testbench

- Slave-mode I2S receiver. Oversamples external SCK/WS/SD in the system clock domain and deserialises 16-bit MSB-first words, left and right.
- Sits directly upstream of the sample FIFO: each completed word is presented as `sample` with a one-cycle `wr_en` pulse into the FIFO write port.
- Honours the FIFO `full` flag and records overruns.

---
 rtl/i2s_rx_deserializer.sv | 151 +++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// Slave-mode I2S receiver: oversamples SCK/WS/SD in the clk domain,
// deserialises WORD_W-bit MSB-first words per channel slot and pushes each
// completed word into a downstream FIFO write port, honouring its full flag.
module i2s_rx_deserializer #(
  parameter int SYNC_STAGES = 2,
  parameter int CHAN_SEL    = 2,
  parameter int WORD_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_sck,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  input  logic              full,
  input  logic              clr_overrun,
  output logic [WORD_W-1:0] sample,
  output logic              sample_right,
  output logic              wr_en,
  output logic              overrun,
  output logic              short_err
);

  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);

  typedef enum logic [1:0] {SYNC, SHIFT, HOLD} state_t;

  state_t            state;
  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic              sck_prev;
  logic              sck_s, ws_s, sd_s;
  logic              sck_rise, boundary;
  logic              ws_q;
  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              chan;
  logic              done;
  logic              done_right;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ws_s     = ws_sync[SYNC_STAGES-1];
  assign sd_s     = sd_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign boundary = sck_rise & (ws_s != ws_q);

  // True when the given channel is forwarded to the FIFO.
  function automatic logic chan_enabled(input logic right);
    return (CHAN_SEL == 2) || (CHAN_SEL == 1 && right) || (CHAN_SEL == 0 && !right);
  endfunction

  // Input synchronisers plus previous-SCK register for rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
      sck_prev <= sck_s;
    end
  end

  // Slot tracking FSM, shifter and registered FIFO-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SYNC;
      ws_q         <= 1'b0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      chan         <= 1'b0;
      done         <= 1'b0;
      done_right   <= 1'b0;
      sample       <= '0;
      sample_right <= 1'b0;
      wr_en        <= 1'b0;
      overrun      <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      short_err <= 1'b0;
      done      <= 1'b0;

      // A new overrun in the same cycle as a clear must win, so set comes last.
      if (clr_overrun) overrun <= 1'b0;

      // Completion cycle: shift_reg is stable here because two sck_rise
      // strobes can never be adjacent.
      if (done && chan_enabled(done_right)) begin
        if (!full) begin
          sample       <= shift_reg;
          sample_right <= done_right;
          wr_en        <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (sck_rise) begin
        ws_q <= ws_s;
        case (state)
          SYNC: begin
            if (boundary) begin
              state   <= SHIFT;
              chan    <= ws_s;
              bit_cnt <= '0;
            end
          end
          SHIFT: begin
            if (boundary) begin
              // The boundary bit is the LSB of the slot just ending: it
              // completes a word that is one bit short, otherwise the slot
              // was truncated.
              if (bit_cnt == LAST_BIT) begin
                shift_reg  <= {shift_reg[WORD_W-2:0], sd_s};
                done       <= 1'b1;
                done_right <= chan;
              end else begin
                short_err <= 1'b1;
              end
              chan    <= ws_s;
              bit_cnt <= '0;
            end else begin
              shift_reg <= {shift_reg[WORD_W-2:0], sd_s};
              bit_cnt   <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                state      <= HOLD;
                bit_cnt    <= FULL_CNT;
                done       <= 1'b1;
                done_right <= chan;
              end
            end
          end
          HOLD: begin
            // Extra bits of wide slots are ignored; counter stays saturated.
            if (boundary) begin
              state   <= SHIFT;
              chan    <= ws_s;
              bit_cnt <= '0;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: a stereo instance and a left-only
// instance share one I2S stream; expected words are queued when each slot
// is driven and checked whenever wr_en pulses.
module tb_i2s_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i2s_sck, i2s_ws, i2s_sd;
  logic        full, full_l, clr_overrun;
  logic [15:0] sample, sample_l;
  logic        sample_right, wr_en, overrun, short_err;
  logic        sample_right_l, wr_en_l, overrun_l, short_err_l;

  always #5 clk = ~clk;

  i2s_rx_deserializer dut (
    .clk(clk), .rst(rst), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .full(full), .clr_overrun(clr_overrun), .sample(sample),
    .sample_right(sample_right), .wr_en(wr_en), .overrun(overrun),
    .short_err(short_err)
  );

  i2s_rx_deserializer #(.CHAN_SEL(0)) dut_l (
    .clk(clk), .rst(rst), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .full(full_l), .clr_overrun(clr_overrun), .sample(sample_l),
    .sample_right(sample_right_l), .wr_en(wr_en_l), .overrun(overrun_l),
    .short_err(short_err_l)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];
  logic [15:0] exp_ql[$];
  logic [16:0] e_m;
  logic [15:0] e_l;
  int   short_cnt = 0, short_cnt_l = 0, exp_short = 0;
  logic wr_prev = 1'b0, wr_prev_l = 1'b0;
  logic synced = 1'b0;
  logic prev_lsb = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare on every write pulse.
  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_en_gap", wr_prev, 0);
      check("spurious_wr_en", exp_q.size() == 0, 0);
      if (exp_q.size() > 0) begin
        e_m = exp_q.pop_front();
        $display("wr_en stereo: sample=0x%04h right=%0d (exp 0x%04h right=%0d)",
                 sample, sample_right, e_m[15:0], e_m[16]);
        check("sample", sample, e_m[15:0]);
        check("sample_right", sample_right, e_m[16]);
      end
    end
    if (wr_en_l) begin
      check("wr_en_gap_l", wr_prev_l, 0);
      check("spurious_wr_en_l", exp_ql.size() == 0, 0);
      check("sample_right_l", sample_right_l, 0);
      if (exp_ql.size() > 0) begin
        e_l = exp_ql.pop_front();
        $display("wr_en left-only: sample=0x%04h (exp 0x%04h)", sample_l, e_l);
        check("sample_l", sample_l, e_l);
      end
    end
    if (short_err) short_cnt++;
    if (short_err_l) short_cnt_l++;
    wr_prev   = wr_en;
    wr_prev_l = wr_en_l;
  end

  // One SCK period (8 clk); optionally pulse clr_overrun in the completion cycle.
  task automatic send_bit(input logic w, input logic d, input logic clr_at_done);
    i2s_sck = 1'b0;
    i2s_ws  = w;
    i2s_sd  = d;
    repeat (4) @(negedge clk);
    i2s_sck = 1'b1;
    if (clr_at_done) begin
      repeat (3) @(negedge clk);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // One slot of n bits, I2S style: first bit carries the previous slot's LSB.
  task automatic send_slot(input logic ch, input int n, input logic [31:0] data,
                           input logic fl, input logic clr_done);
    logic [15:0] w;
    full = fl;
    if (synced && n >= 16) begin
      w = data[n-1 -: 16];
      if (!fl) exp_q.push_back({ch, w});
      if (!ch) exp_ql.push_back(w);
    end
    if (synced && n < 16) exp_short++;
    send_bit(ch, prev_lsb, 1'b0);
    for (int i = n - 1; i >= 1; i--) send_bit(ch, data[i], clr_done && (i == n - 16));
    prev_lsb = data[0];
    synced   = 1'b1;
    full     = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_sample_right"}, sample_right, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_short_err"}, short_err, 0);
  endtask

  task automatic check_drained(input string tag);
    repeat (8) @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_pending_l"}, exp_ql.size(), 0);
  endtask

  initial begin
    rst = 1'b1; i2s_sck = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0;
    full = 1'b0; full_l = 1'b0; clr_overrun = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Partial left slot after reset is discarded, then stereo frames.
    send_slot(1'b0, 9, 32'h0000_01A5, 1'b0, 1'b0);
    send_slot(1'b1, 16, 32'h0000_FEDC, 1'b0, 1'b0);
    send_slot(1'b0, 16, 32'h0000_A5C3, 1'b0, 1'b0);
    send_slot(1'b1, 16, 32'h0000_1234, 1'b0, 1'b0);
    send_slot(1'b0, 16, 32'h0000_A5C3, 1'b0, 1'b0);
    send_slot(1'b1, 16, 32'h0000_1234, 1'b0, 1'b0);
    send_slot(1'b0, 20, 32'h0005_A5A5, 1'b0, 1'b0);
    check_drained("stereo");

    // 32-bit slots: only the top 16 bits are captured.
    send_slot(1'b1, 32, 32'h0001_FFFF, 1'b0, 1'b0);
    send_slot(1'b0, 32, 32'hFFFF_0000, 1'b0, 1'b0);
    send_slot(1'b1, 20, 32'h0002_468A, 1'b0, 1'b0);
    check_drained("wide");
    check("wide_no_short", short_cnt, 0);

    // Truncated right slot of 10 bits.
    send_slot(1'b0, 16, 32'h0000_1357, 1'b0, 1'b0);
    send_slot(1'b1, 10, 32'h0000_02AB, 1'b0, 1'b0);
    send_slot(1'b0, 16, 32'h0000_8001, 1'b0, 1'b0);
    send_slot(1'b1, 20, 32'h000A_BCDE, 1'b0, 1'b0);
    check_drained("short");
    check("short_count", short_cnt, exp_short);
    check("short_count_l", short_cnt_l, exp_short);

    // FIFO full on a right completion, clear, then clear colliding with a set.
    send_slot(1'b0, 20, 32'h000C_3C3C, 1'b0, 1'b0);
    send_slot(1'b1, 20, 32'h0007_7777, 1'b1, 1'b0);
    check("overrun_set", overrun, 1);
    check("overrun_keeps_sample", sample, 16'hC3C3);
    check("overrun_keeps_right", sample_right, 0);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    @(negedge clk);
    check("overrun_cleared", overrun, 0);
    send_slot(1'b0, 20, 32'h0001_1111, 1'b0, 1'b0);
    send_slot(1'b1, 20, 32'h0002_2222, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("overrun_set_wins", overrun, 1);
    check("overrun_l_never", overrun_l, 0);
    check_drained("overrun");

    // Reset in the middle of a right slot after 8 data bits.
    send_slot(1'b0, 16, 32'h0000_0F0F, 1'b0, 1'b0);
    send_bit(1'b1, prev_lsb, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, i[0], 1'b0);
    check("pre_reset_sample", sample, 16'h0F0F);
    i2s_sck = 1'b0;
    i2s_ws  = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("mid_reset");
    rst    = 1'b0;
    synced = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_values("post_reset");
    send_slot(1'b0, 16, 32'h0000_AAAA, 1'b0, 1'b0);
    send_slot(1'b1, 16, 32'h0000_5555, 1'b0, 1'b0);
    send_slot(1'b0, 20, 32'h0009_9999, 1'b0, 1'b0);
    check_drained("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
